// File: rtl/i2c_target.sv
// I2C target (7-bit addressing): detects START/STOP, matches its address,
// ACKs matching transfers, delivers written bytes and serialises read bytes.
// Open-drain SDA only, no clock stretching.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   scl_in, sda_in    raw (asynchronous) bus pin levels
//   sda_oe            1 = pull SDA low, 0 = release
//   busy              high while this target is addressed
//   rx_data/rx_valid  last written byte and its one-cycle strobe
//   tx_data/tx_req    read byte and its one-cycle request strobe
//   rw                R/W bit of the current transfer (1 = read)
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    logic             scl_m, scl_s, scl_p;
    logic             sda_m, sda_s, sda_p;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    // ACK phases: set once the first falling edge of the ACK slot was seen
    // (ADDR_ACK/RX_ACK) or once the controller ACKed (TX_ACK).
    logic             phase_q, phase_d;
    logic             sda_oe_d, busy_d, rx_valid_d, tx_req_d, rw_d;
    logic [7:0]       rx_data_d;

    logic scl_rise, scl_fall, start, stop;

    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign start    = sda_p & ~sda_s & scl_s & scl_p;
    assign stop     = ~sda_p & sda_s & scl_s & scl_p;

    // Synchronisers and previous-value flops; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {scl_m, scl_s, scl_p} <= 3'b111;
            {sda_m, sda_s, sda_p} <= 3'b111;
        end else begin
            {scl_m, scl_s, scl_p} <= {scl_in, scl_m, scl_s};
            {sda_m, sda_s, sda_p} <= {sda_in, sda_m, sda_s};
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= 8'h00;
            phase_q   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            rw        <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            phase_q   <= phase_d;
            sda_oe    <= sda_oe_d;
            busy      <= busy_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            tx_req    <= tx_req_d;
            rw        <= rw_d;
        end
    end

    // Next-state and output logic; bus conditions override SCL edges.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe;
        busy_d     = busy;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        rw_d       = rw;

        if (start) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            rw_d    = sda_s;
                            phase_d = 1'b0;
                            state_d = (shift_q[6:0] == ADDRESS) ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            bit_cnt_d = '0;
                            if (rw) begin
                                shift_d  = tx_data;
                                sda_oe_d = ~tx_data[7];
                                state_d  = TX;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = RX;
                            end
                        end
                    end else if (scl_rise && phase_q && rw) begin
                        tx_req_d = 1'b1;
                    end
                end
                RX: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b0;
                            state_d    = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = RX;
                        end
                    end
                end
                TX: begin
                    // Each fall presents the next bit; the fall ending bit 0 releases SDA.
                    if (scl_fall) begin
                        if (bit_cnt_q == CNT_W'(7)) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            state_d   = TX_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall && phase_q) begin
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = '0;
                        state_d   = TX;
                    end
                end
                // IDLE and WAIT_STOP: keep SDA released until START/STOP.
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

endmodule
